// File: rtl/jtframe_prog_packer_if.sv
// SDRAM programming bus between the ROM download packer and the SDRAM controller.
// Latency: none, wires only.
// Backpressure: prog_we is held by the packer until the controller answers with prog_rdy.
//
// Ports (master = packer side):
//   prog_addr  22  word address inside the selected bank
//   prog_data   8  byte value, the controller replicates it on both lanes
//   prog_mask   2  active-low lane enable
//   prog_bank   2  target bank
//   prog_we     1  write request, held until prog_rdy
//   prom_we     1  one-cycle PROM strobe, qualifies prog_addr/prog_data
//   prog_rdy    1  controller has committed the current write
interface jtframe_prog_packer_if;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prom_we;
  logic        prog_rdy;

  modport master (
    output prog_addr, prog_data, prog_mask, prog_bank, prog_we, prom_we,
    input  prog_rdy
  );

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_bank, prog_we, prom_we,
    output prog_rdy
  );
endinterface

// File: rtl/jtframe_prog_packer.sv
// Packs the ioctl ROM download byte stream into SDRAM bank writes and PROM strobes.
// Latency: ioctl_wr in cycle N gives prog_we/prom_we in cycle N+2 when idle.
// Backpressure: prog_we held until prog_rdy; two bytes queue behind it, further bytes are dropped and flag ovf.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   downloading          download in progress (rising edge clears ovf)
//   ioctl_addr/data/wr   byte stream from the downloader
//   prog                 SDRAM programming bus (see jtframe_prog_packer_if)
//   dwnld_busy           downloading, or bytes still queued or in flight
//   ovf                  sticky: a byte was lost because the queue was full

// Small generic FIFO. A push while full is accepted only if a pop happens in
// the same cycle, so occupancy stays unchanged in that case.
module jtframe_prog_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module jtframe_prog_packer #(
  parameter int          HEADER     = 0,
  parameter logic [24:0] BA1_START  = 25'h100000,
  parameter logic [24:0] BA2_START  = 25'h200000,
  parameter logic [24:0] BA3_START  = 25'h300000,
  parameter logic [24:0] PROM_START = 25'h1FFFFFF,
  parameter bit          SWAB       = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         downloading,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_data,
  input  logic                         ioctl_wr,
  jtframe_prog_packer_if.master        prog,
  output logic                         dwnld_busy,
  output logic                         ovf
);
  typedef struct packed {
    logic        prom;
    logic [1:0]  bank;
    logic [21:0] addr;
    logic        lane;
    logic [7:0]  data;
  } ent_t;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t      st, st_nxt;
  ent_t        cap_ent, dec_ent, fifo_dout, head;
  logic        dec_vld, dl_q, in_hdr, capture;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic        load, done, bypass, drop;
  logic [24:0] off;
  logic [22:0] rel;

  // A zero-length header never discards anything; keep the compare out of
  // the netlist in that case.
  generate
    if (HEADER == 0) begin : g_nohdr
      assign in_hdr = 1'b0;
    end else begin : g_hdr
      assign in_hdr = (ioctl_addr < 25'(HEADER));
    end
  endgenerate

  assign capture = downloading && ioctl_wr && !in_hdr;

  // Range decode on the raw byte, registered into dec_ent. PROM wins over
  // the bank ranges; bank ranges are checked from the top down.
  always_comb begin
    cap_ent = '0;
    off     = ioctl_addr - 25'(HEADER);
    rel     = 23'(off);
    if (off >= PROM_START) begin
      cap_ent.prom = 1'b1;
      rel          = {1'b0, 22'(off - PROM_START)};
    end else if (off >= BA3_START) begin
      cap_ent.bank = 2'd3;
      rel          = 23'(off - BA3_START);
    end else if (off >= BA2_START) begin
      cap_ent.bank = 2'd2;
      rel          = 23'(off - BA2_START);
    end else if (off >= BA1_START) begin
      cap_ent.bank = 2'd1;
      rel          = 23'(off - BA1_START);
    end
    cap_ent.addr = rel[22:1];
    cap_ent.lane = rel[0] ^ SWAB;
    cap_ent.data = ioctl_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_vld <= 1'b0;
      dec_ent <= '0;
      dl_q    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      dec_vld <= capture;
      if (capture) dec_ent <= cap_ent;
      dl_q <= downloading;
      if (downloading && !dl_q) ovf <= 1'b0;
      else if (drop)            ovf <= 1'b1;
    end
  end

  jtframe_prog_fifo #(.W($bits(ent_t)), .DEPTH(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (dec_ent),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // With an empty FIFO the decode stage feeds the output registers directly,
  // which is what gives the two-cycle latency. The entry leaves the FIFO as
  // soon as it is loaded, so the output registers act as a third slot.
  assign head      = fifo_empty ? dec_ent : fifo_dout;
  assign fifo_push = dec_vld && !bypass;
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    load     = 1'b0;
    done     = 1'b0;
    bypass   = 1'b0;
    fifo_pop = 1'b0;
    case (st)
      IDLE: begin
        if (!fifo_empty || dec_vld) begin
          load     = 1'b1;
          fifo_pop = !fifo_empty;
          bypass   = fifo_empty;
          st_nxt   = head.prom ? GAP : WAIT;
        end
      end
      WAIT: begin
        if (prog.prog_rdy) begin
          done   = 1'b1;
          st_nxt = GAP;
        end
      end
      GAP:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog.prog_addr <= '0;
      prog.prog_data <= '0;
      prog.prog_mask <= 2'b11;
      prog.prog_bank <= '0;
      prog.prog_we   <= 1'b0;
      prog.prom_we   <= 1'b0;
    end else begin
      prog.prom_we <= 1'b0;
      if (load) begin
        prog.prog_addr <= head.addr;
        prog.prog_data <= head.data;
        if (head.prom) begin
          prog.prom_we <= 1'b1;
        end else begin
          prog.prog_bank <= head.bank;
          prog.prog_mask <= head.lane ? 2'b01 : 2'b10;
          prog.prog_we   <= 1'b1;
        end
      end
      if (done) begin
        prog.prog_we   <= 1'b0;
        prog.prog_mask <= 2'b11;
      end
    end
  end

  assign dwnld_busy = downloading || !fifo_empty || (st != IDLE) || dec_vld;
endmodule

// File: tb/tb_jtframe_prog_packer.sv
module tb_jtframe_prog_packer;
  typedef struct packed {
    logic        prom;
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } exp_t;

  logic clk, rst;
  logic dl_a, dl_b, wr_a_s, wr_b_s;
  logic [24:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic busy_a, busy_b, ovf_a, ovf_b;

  logic       rdy_en_a, rdy_en_b, rdy_force_a;
  int         rdy_dly_a, rdy_dly_b;
  logic       we_q_a, we_q_b;
  exp_t       exp_a[$], exp_b[$];
  exp_t       cur_a, cur_b, pe_a, pe_b;
  int         checks, failures;

  jtframe_prog_packer_if a_if();
  jtframe_prog_packer_if b_if();

  jtframe_prog_packer #(.HEADER(4)) dut_a (
    .clk(clk), .rst(rst), .downloading(dl_a), .ioctl_addr(addr_a),
    .ioctl_data(data_a), .ioctl_wr(wr_a_s), .prog(a_if),
    .dwnld_busy(busy_a), .ovf(ovf_a)
  );

  jtframe_prog_packer #(
    .HEADER(0), .BA1_START(25'h4000), .BA2_START(25'h8000),
    .BA3_START(25'hC000), .PROM_START(25'h10000), .SWAB(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .downloading(dl_b), .ioctl_addr(addr_b),
    .ioctl_data(data_b), .ioctl_wr(wr_b_s), .prog(b_if),
    .dwnld_busy(busy_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic prom, input logic [1:0] bank,
                              input logic [21:0] addr, input logic [1:0] mask,
                              input logic [7:0] data);
    exp_t e;
    e.prom = prom; e.bank = bank; e.addr = addr; e.mask = mask; e.data = data;
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_a(input logic [24:0] ad, input logic [7:0] d);
    addr_a = ad; data_a = d; wr_a_s = 1'b1; cyc(1); wr_a_s = 1'b0;
  endtask

  task automatic wr_b(input logic [24:0] ad, input logic [7:0] d);
    addr_b = ad; data_b = d; wr_b_s = 1'b1; cyc(1); wr_b_s = 1'b0;
  endtask

  // SDRAM controller models: answer prog_rdy a fixed number of cycles after prog_we rises.
  initial begin
    a_if.prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      a_if.prog_rdy = 1'b0;
      if (rdy_force_a) a_if.prog_rdy = 1'b1;
      else if (rdy_en_a && a_if.prog_we) begin
        repeat (rdy_dly_a - 1) @(negedge clk);
        a_if.prog_rdy = 1'b1;
      end
    end
  end

  initial begin
    b_if.prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      b_if.prog_rdy = 1'b0;
      if (rdy_en_b && b_if.prog_we) begin
        repeat (rdy_dly_b - 1) @(negedge clk);
        b_if.prog_rdy = 1'b1;
      end
    end
  end

  // Monitors: pop the scoreboard on each new SDRAM write or PROM strobe,
  // and keep checking the held write against its expectation while prog_we stays high.
  initial begin
    we_q_a = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && a_if.prog_we && !we_q_a) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL A_unexpected_write actual addr=%h data=%h required none", a_if.prog_addr, a_if.prog_data);
        end else begin
          cur_a = exp_a.pop_front();
          cmp("A_write", 64'({1'b0, a_if.prog_bank, a_if.prog_addr, a_if.prog_mask, a_if.prog_data}), 64'(cur_a));
        end
      end else if (!rst && a_if.prog_we) begin
        cmp("A_hold", 64'({1'b0, a_if.prog_bank, a_if.prog_addr, a_if.prog_mask, a_if.prog_data}), 64'(cur_a));
      end
      if (!rst && a_if.prom_we) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL A_unexpected_prom actual addr=%h required none", a_if.prog_addr);
        end else begin
          pe_a = exp_a.pop_front();
          cmp("A_prom", 64'({a_if.prom_we, a_if.prog_we, a_if.prog_addr, a_if.prog_data}), 64'({pe_a.prom, 1'b0, pe_a.addr, pe_a.data}));
        end
      end
      we_q_a = a_if.prog_we;
    end
  end

  initial begin
    we_q_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && b_if.prog_we && !we_q_b) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL B_unexpected_write actual addr=%h data=%h required none", b_if.prog_addr, b_if.prog_data);
        end else begin
          cur_b = exp_b.pop_front();
          cmp("B_write", 64'({1'b0, b_if.prog_bank, b_if.prog_addr, b_if.prog_mask, b_if.prog_data}), 64'(cur_b));
        end
      end else if (!rst && b_if.prog_we) begin
        cmp("B_hold", 64'({1'b0, b_if.prog_bank, b_if.prog_addr, b_if.prog_mask, b_if.prog_data}), 64'(cur_b));
      end
      if (!rst && b_if.prom_we) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL B_unexpected_prom actual addr=%h required none", b_if.prog_addr);
        end else begin
          pe_b = exp_b.pop_front();
          cmp("B_prom", 64'({b_if.prom_we, b_if.prog_we, b_if.prog_addr, b_if.prog_data}), 64'({pe_b.prom, 1'b0, pe_b.addr, pe_b.data}));
        end
      end
      we_q_b = b_if.prog_we;
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; dl_a = 1'b0; dl_b = 1'b0; wr_a_s = 1'b0; wr_b_s = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    rdy_en_a = 1'b1; rdy_en_b = 1'b1; rdy_force_a = 1'b0;
    rdy_dly_a = 3; rdy_dly_b = 2;
    cyc(3);
    // {addr,data,mask,bank,we,prom_we,busy,ovf}
    cmp("A_reset", 64'({a_if.prog_addr, a_if.prog_data, a_if.prog_mask, a_if.prog_bank, a_if.prog_we, a_if.prom_we, busy_a, ovf_a}),
        64'({22'd0, 8'd0, 2'b11, 2'd0, 4'b0000}));
    cmp("B_reset", 64'({b_if.prog_addr, b_if.prog_data, b_if.prog_mask, b_if.prog_bank, b_if.prog_we, b_if.prom_we, busy_b, ovf_b}),
        64'({22'd0, 8'd0, 2'b11, 2'd0, 4'b0000}));
    rst = 1'b0;
    cyc(2);

    // Instance B: SWAB=1, small bank map, PROM from 0x10000
    dl_b = 1'b1;
    exp_b.push_back(mk(1'b0, 2'd2, 22'd1, 2'b10, 8'h7E));
    wr_b(25'h8003, 8'h7E);
    cyc(12);
    exp_b.push_back(mk(1'b1, 2'd0, 22'd2, 2'b11, 8'hC3));
    wr_b(25'h10005, 8'hC3);
    cmp("B_prom_lat_n1", 64'(b_if.prom_we), 64'(0));
    cyc(1);
    cmp("B_prom_lat_n2", 64'({b_if.prom_we, b_if.prog_we}), 64'(2'b10));
    cyc(1);
    cmp("B_prom_one_cycle", 64'(b_if.prom_we), 64'(0));
    cyc(4);
    exp_b.push_back(mk(1'b0, 2'd1, 22'd8, 2'b01, 8'h11));
    wr_b(25'h4010, 8'h11);
    cyc(10);
    exp_b.push_back(mk(1'b0, 2'd3, 22'd3, 2'b10, 8'h33));
    wr_b(25'hC007, 8'h33);
    cyc(10);
    exp_b.push_back(mk(1'b0, 2'd0, 22'd0, 2'b01, 8'h99));
    wr_b(25'h0, 8'h99);
    cyc(10);
    dl_b = 1'b0;
    wr_b(25'h10, 8'hEE);   // ignored: not downloading
    cyc(5);
    cmp("B_idle_busy", 64'({busy_b, ovf_b}), 64'(0));

    // Test 1: 4-byte header stripped
    dl_a = 1'b1;
    exp_a.push_back(mk(1'b0, 2'd0, 22'd0, 2'b10, 8'hA5));
    exp_a.push_back(mk(1'b0, 2'd0, 22'd0, 2'b01, 8'h5A));
    wr_a(25'd0, 8'h11); wr_a(25'd1, 8'h22); wr_a(25'd2, 8'h33); wr_a(25'd3, 8'h44);
    cyc(3);
    cmp("A_header_no_write", 64'(a_if.prog_we), 64'(0));
    wr_a(25'd4, 8'hA5);
    cmp("A_lat_n1", 64'(a_if.prog_we), 64'(0));
    wr_a(25'd5, 8'h5A);
    cmp("A_lat_n2", 64'(a_if.prog_we), 64'(1));
    cyc(20);

    // Test 2: bank 2 decode
    exp_a.push_back(mk(1'b0, 2'd2, 22'd1, 2'b01, 8'h7E));
    wr_a(25'h200007, 8'h7E);
    cyc(12);

    // Test 3: controller stalls 20 cycles, fourth byte overflows
    rdy_dly_a = 20;
    exp_a.push_back(mk(1'b0, 2'd0, 22'h8, 2'b10, 8'h01));
    exp_a.push_back(mk(1'b0, 2'd0, 22'h8, 2'b01, 8'h02));
    exp_a.push_back(mk(1'b0, 2'd0, 22'h9, 2'b10, 8'h03));
    wr_a(25'h14, 8'h01); cyc(1);
    wr_a(25'h15, 8'h02); cyc(1);
    wr_a(25'h16, 8'h03); cyc(1);
    wr_a(25'h17, 8'h04);
    cmp("A_ovf_before_drop", 64'(ovf_a), 64'(0));
    cyc(1);
    cmp("A_ovf_set", 64'(ovf_a), 64'(1));
    cyc(80);
    cmp("A_ovf_sticky", 64'(ovf_a), 64'(1));
    dl_a = 1'b0;
    cyc(3);
    cmp("A_ovf_after_fall", 64'({ovf_a, busy_a}), 64'(2'b10));
    dl_a = 1'b1;
    cyc(1);
    cmp("A_ovf_cleared", 64'(ovf_a), 64'(0));
    rdy_dly_a = 3;
    cyc(2);

    // Test 5: downloading falls with two bytes in flight
    exp_a.push_back(mk(1'b0, 2'd0, 22'h10, 2'b10, 8'h55));
    exp_a.push_back(mk(1'b0, 2'd0, 22'h10, 2'b01, 8'hAA));
    wr_a(25'h24, 8'h55);
    wr_a(25'h25, 8'hAA);
    dl_a = 1'b0;
    cyc(8);
    cmp("A_busy_in_gap", 64'({busy_a, a_if.prog_we}), 64'(2'b10));
    cyc(1);
    cmp("A_busy_drop", 64'(busy_a), 64'(0));
    cyc(3);

    // Test 6: reset while waiting with the FIFO full
    rdy_en_a = 1'b0;
    dl_a = 1'b1;
    exp_a.push_back(mk(1'b0, 2'd0, 22'h18, 2'b10, 8'h61));
    wr_a(25'h34, 8'h61); cyc(1);
    wr_a(25'h35, 8'h62); cyc(1);
    wr_a(25'h36, 8'h63); cyc(3);
    cmp("A_full_no_ovf", 64'({a_if.prog_we, ovf_a}), 64'(2'b10));
    rst = 1'b1; dl_a = 1'b0;
    cyc(1);
    cmp("A_mid_reset", 64'({a_if.prog_addr, a_if.prog_data, a_if.prog_mask, a_if.prog_bank, a_if.prog_we, a_if.prom_we, busy_a, ovf_a}),
        64'({22'd0, 8'd0, 2'b11, 2'd0, 4'b0000}));
    rst = 1'b0;
    repeat (3) begin
      cyc(2);
      rdy_force_a = 1'b1; cyc(1); rdy_force_a = 1'b0;
    end
    cyc(6);
    cmp("A_after_reset_quiet", 64'({a_if.prog_we, a_if.prom_we, busy_a}), 64'(0));

    cmp("A_scoreboard_drained", 64'(exp_a.size()), 64'(0));
    cmp("B_scoreboard_drained", 64'(exp_b.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
